// File: rtl/nvram_upload_responder.sv
// nvram_upload_responder: shadows core NVRAM writes into a byte RAM, tracks a
// dirty flag, requests an HPS save after a quiet period and serves ioctl_din
// during the upload. Runs on the 49 MHz system clock.
module nvram_upload_responder #(
    parameter int              AW           = 12,
    parameter logic [AW-1:0]   WIN_BASE     = '0,
    parameter logic [AW:0]     WIN_LEN      = {1'b1, {AW{1'b0}}},
    parameter logic [7:0]      UPLOAD_INDEX = 8'd4,
    parameter int              QUIET_CYCLES = 49152000
) (
    input  logic          clk_49m,
    input  logic          reset,
    input  logic          enable,
    input  logic [AW-1:0] snoop_addr,
    input  logic [7:0]    snoop_data,
    input  logic          snoop_we,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic [24:0]   ioctl_addr,
    input  logic          ioctl_rd,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_upload_req,
    output logic          dirty,
    output logic          busy
);

    localparam int              CW       = $clog2(QUIET_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(QUIET_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(QUIET_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        QUIET,
        REQ,
        WAIT_UP,
        UPLOADING
    } state_t;

    // One read in flight: its strobe and whether it fell outside the window.
    typedef struct packed {
        logic vld;
        logic oor;
    } rd_stage_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            dirty_n;
    logic            rewrite, rewrite_n;
    logic            hit_q;
    logic            up_sel, up_sel_q, up_rise, up_fall;
    logic [AW:0]     win_off;
    logic            in_win;
    logic            rd_hit, rd_oor;
    rd_stage_t       rd_pipe;
    logic [7:0]      rd_byte;

    // Power-up contents are zero; reset never touches the RAM.
    logic [7:0]      shadow [0:(1<<AW)-1] = '{default: 8'h00};

    // Window decode: offset is only meaningful once snoop_addr >= WIN_BASE.
    assign win_off = {1'b0, snoop_addr} - {1'b0, WIN_BASE};
    assign in_win  = snoop_we && (snoop_addr >= WIN_BASE) && (win_off < WIN_LEN);

    assign up_sel  = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign up_rise = up_sel && !up_sel_q;
    assign up_fall = !up_sel && up_sel_q;

    assign rd_hit  = ioctl_rd && up_sel;
    assign rd_oor  = (ioctl_addr >= {{(24-AW){1'b0}}, WIN_LEN});

    assign busy             = (state == UPLOADING);
    assign ioctl_upload_req = (state == REQ) && enable;

    // Shadow RAM: snoop write port plus read-first upload read port.
    always_ff @(posedge clk_49m) begin
        if (in_win)
            shadow[win_off[AW-1:0]] <= snoop_data;
        if (rd_hit)
            rd_byte <= shadow[ioctl_addr[AW-1:0]];
    end

    // Second read stage: present the byte (or 0xFF past the window) and hold it.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            rd_pipe   <= '0;
            ioctl_din <= 8'h00;
        end else begin
            rd_pipe.vld <= rd_hit;
            rd_pipe.oor <= rd_oor;
            if (rd_pipe.vld)
                ioctl_din <= rd_pipe.oor ? 8'hFF : rd_byte;
        end
    end

    // State, timer and flag registers.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            dirty    <= 1'b0;
            rewrite  <= 1'b0;
            hit_q    <= 1'b0;
            up_sel_q <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dirty    <= dirty_n;
            rewrite  <= rewrite_n;
            hit_q    <= in_win;
            up_sel_q <= up_sel;
        end
    end

    // Next-state logic. The quiet timer is held clear on the write clock and
    // the one after, so it starts counting from the clock dirty is visible,
    // giving the same request latency whether the write lands in IDLE or QUIET.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        dirty_n   = dirty || in_win;
        rewrite_n = rewrite;
        case (state)
            IDLE: begin
                if (up_rise) begin
                    state_n = UPLOADING;
                end else if (enable && dirty) begin
                    state_n = QUIET;
                    cnt_n   = '0;
                end
            end
            QUIET: begin
                if (up_rise) begin
                    state_n = UPLOADING;
                end else if (!enable) begin
                    state_n = IDLE;
                end else if (in_win || hit_q) begin
                    cnt_n = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = REQ;
                    cnt_n   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            REQ: begin
                if (up_rise) begin
                    state_n = UPLOADING;
                end else if (!enable) begin
                    state_n = IDLE;
                end else begin
                    state_n = WAIT_UP;
                    cnt_n   = '0;
                end
            end
            WAIT_UP: begin
                if (up_rise) begin
                    state_n = UPLOADING;
                end else if (!enable) begin
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    // HPS never picked up the request; go round again.
                    state_n = QUIET;
                    cnt_n   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            UPLOADING: begin
                if (in_win)
                    rewrite_n = 1'b1;
                if (up_fall) begin
                    // A write on the closing clock missed the saved image too.
                    state_n   = IDLE;
                    dirty_n   = rewrite || in_win;
                    rewrite_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nvram_upload_responder.sv
// Scoreboard bench for nvram_upload_responder: stimulus pushes expected
// request cycles and read bytes; a negedge monitor pops and compares.
module tb_nvram_upload_responder;

    localparam int          AW   = 12;
    localparam logic [11:0] BASE = 12'h010;
    localparam int          QC   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] snoop_addr = '0;
    logic [7:0]  snoop_data = '0;
    logic        snoop_we = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = '0;
    logic [24:0] ioctl_addr = '0;
    logic        ioctl_rd = 1'b0;
    logic [7:0]  ioctl_din;
    logic        ioctl_upload_req;
    logic        dirty;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int         at;
        logic [7:0] val;
    } rd_exp_t;

    int      req_q[$];
    rd_exp_t rd_q[$];

    nvram_upload_responder #(
        .AW(AW), .WIN_BASE(BASE), .WIN_LEN(13'd64),
        .UPLOAD_INDEX(8'd4), .QUIET_CYCLES(QC)
    ) dut (
        .clk_49m(clk), .reset(rst_n), .enable(enable),
        .snoop_addr(snoop_addr), .snoop_data(snoop_data), .snoop_we(snoop_we),
        .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd),
        .ioctl_din(ioctl_din), .ioctl_upload_req(ioctl_upload_req),
        .dirty(dirty), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every request pulse must match a queued cycle; read bytes are
    // compared on the cycle they are due.
    always @(negedge clk) begin : mon
        rd_exp_t e;
        if (ioctl_upload_req === 1'b1) begin
            if (req_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL req_unexpected: got pulse at cycle %0d want none", cyc);
            end else begin
                chk("req_cycle", cyc, req_q.pop_front());
            end
        end
        while (rd_q.size() > 0 && rd_q[0].at <= cyc) begin
            e = rd_q.pop_front();
            if (e.at < cyc) begin
                total++;
                bad++;
                $display("FAIL din_missed: got check at %0d want %0d", cyc, e.at);
            end else begin
                chk("din", ioctl_din, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic snoop(input logic [11:0] a, input logic [7:0] d);
        snoop_we   = 1'b1;
        snoop_addr = a;
        snoop_data = d;
        tick();
        snoop_we   = 1'b0;
    endtask

    // Read strobe; byte due 2 clocks later and still held one clock after.
    task automatic rd(input logic [24:0] a, input logic [7:0] exp);
        rd_q.push_back('{at: cyc + 2, val: exp});
        rd_q.push_back('{at: cyc + 3, val: exp});
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        tick();
        ioctl_rd   = 1'b0;
        tick();
    endtask

    task automatic up_start(input logic [7:0] idx);
        ioctl_upload = 1'b1;
        ioctl_index  = idx;
        tick();
    endtask

    task automatic up_end();
        ioctl_upload = 1'b0;
        tick();
    endtask

    initial begin
        int k;
        tick();
        tick();
        chk("rst_din", ioctl_din, 8'h00);
        chk("rst_req", ioctl_upload_req, 1'b0);
        chk("rst_dirty", dirty, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();

        // Writes just below and just past the window are ignored.
        snoop(12'h00F, 8'hEE);
        snoop(12'h050, 8'hEE);
        tick();
        chk("dirty_outside", dirty, 1'b0);

        // Single write -> request 17 clocks after its edge, then a retry
        // when the HPS does not respond within QC clocks.
        k = cyc;
        snoop(BASE + 12'd5, 8'hA5);
        req_q.push_back(k + 18);
        req_q.push_back(k + 51);
        chk("dirty_set", dirty, 1'b1);
        wait_to(k + 52);

        // Upload: reads, window boundary, high address bits, read-first.
        up_start(8'd4);
        chk("busy_up1", busy, 1'b1);
        rd(25'd5, 8'hA5);
        rd(25'd64, 8'hFF);
        snoop(BASE + 12'd6, 8'h11);
        rd_q.push_back('{at: cyc + 2, val: 8'h11});
        rd_q.push_back('{at: cyc + 3, val: 8'h11});
        snoop_we = 1'b1; snoop_addr = BASE + 12'd6; snoop_data = 8'h22;
        ioctl_rd = 1'b1; ioctl_addr = 25'd6;
        tick();
        snoop_we = 1'b0; ioctl_rd = 1'b0;
        tick();
        rd(25'd6, 8'h22);
        snoop(BASE + 12'd63, 8'h3C);
        rd(25'd63, 8'h3C);
        rd(25'h1000005, 8'hFF);

        // Written during upload -> still dirty -> second request.
        k = cyc;
        up_end();
        chk("busy_end1", busy, 1'b0);
        chk("dirty_rewrite", dirty, 1'b1);
        req_q.push_back(k + 18);
        wait_to(k + 19);
        up_start(8'd4);
        chk("busy_up2", busy, 1'b1);

        // Write on the closing clock counts as a rewrite.
        k = cyc;
        snoop_we = 1'b1; snoop_addr = BASE + 12'd7; snoop_data = 8'h5A;
        ioctl_upload = 1'b0;
        tick();
        snoop_we = 1'b0;
        chk("dirty_fall_write", dirty, 1'b1);
        chk("busy_end2", busy, 1'b0);
        req_q.push_back(k + 18);
        wait_to(k + 19);
        up_start(8'd4);
        rd(25'd7, 8'h5A);
        up_end();
        chk("dirty_clean", dirty, 1'b0);
        repeat (30) tick();

        // Writes every 10 clocks hold the timer off until the last one.
        k = 0;
        for (int i = 0; i < 4; i++) begin
            k = cyc;
            snoop(BASE + 12'd8 + 12'(i), 8'h40 + 8'(i));
            if (i < 3) repeat (9) tick();
        end
        req_q.push_back(k + 18);
        wait_to(k + 19);

        // Autosave disabled: abandon the pending request, keep dirty.
        enable = 1'b0;
        repeat (40) tick();
        chk("dirty_kept_dis", dirty, 1'b1);
        chk("busy_dis", busy, 1'b0);

        // Upload for another index is not ours: din untouched.
        up_start(8'd3);
        chk("busy_idx3", busy, 1'b0);
        rd(25'd5, 8'h5A);
        up_end();
        chk("dirty_kept_idx3", dirty, 1'b1);

        // Reset mid-upload, then a clean upload afterwards.
        up_start(8'd4);
        chk("busy_manual", busy, 1'b1);
        rd(25'd5, 8'hA5);
        rd(25'd6, 8'h22);
        rd(25'd63, 8'h3C);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_din", ioctl_din, 8'h00);
        chk("rst_mid_busy", busy, 1'b0);
        ioctl_upload = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("dirty_after_rst", dirty, 1'b0);
        up_start(8'd4);
        chk("busy_after_rst", busy, 1'b1);
        rd(25'd5, 8'hA5);
        rd(25'd63, 8'h3C);
        up_end();
        chk("busy_final", busy, 1'b0);
        repeat (5) tick();

        chk("req_q_empty", req_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
